key_report_tx: RTL and testbench

Serial reporter for the DES key-search engine. When the search engine's `found` flag rises, this block captures the 64-bit key and 56-bit trial count, then transmits them as one ASCII line over a UART TX pin (8N1, LSB first). On the FPGA demo it sits beside the 7-segment display path and consumes the same search-engine outputs, so the full key can be read on a host terminal.

---
 rtl/des_report_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 58 +++++
 rtl/key_report_tx.sv | 110 +++++++++++
 tb/tb_key_report_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_report_pkg.sv
// Shared constants, ASCII helpers and FSM state type for the DES key-search serial reporter.
package des_report_pkg;

  localparam int unsigned FRAME_LEN = 37;
  localparam int unsigned IDX_W     = 6;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_EQ = 8'h3D;

  // SEND covers both waiting on the byte transmitter and handing over the next
  // character, which happens in the final stop-bit cycle so there is no gap.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FIN
  } report_state_t;

  // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first; accepts a new byte during the last stop-bit cycle.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 1085
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        STOP_BIT = 4'd9;

  logic              active;
  logic [3:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [7:0]        shreg;
  logic              bit_end;

  assign bit_end = (baud_cnt == BAUD_MAX);
  assign ready   = ~active | (bit_end & (bit_cnt == STOP_BIT));

  // bit_cnt: 0 = start, 1..8 = data, 9 = stop; shreg refills with 1s so the stop bit falls out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      active   <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= '0;
    end else if (start && ready) begin
      tx       <= 1'b0;
      active   <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= data;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == STOP_BIT) begin
          tx      <= 1'b1;
          active  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_report_tx.sv
// Captures key/count on a rising found edge and sends "K=<16 hex> C=<14 hex>\r\n" over UART.
module key_report_tx
  import des_report_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1085
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        found,
  input  logic [63:0] key,
  input  logic [55:0] count,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  report_state_t    state;
  logic             found_q;
  logic [IDX_W-1:0] char_idx;
  logic [63:0]      key_sh;
  logic [55:0]      cnt_sh;

  logic             trigger;
  logic             last_char;
  logic             tx_ready;
  logic             tx_start;
  logic [IDX_W-1:0] char_sel;
  logic [3:0]       kpos;
  logic [3:0]       cpos;
  logic [3:0]       key_nib;
  logic [3:0]       cnt_nib;
  logic [63:0]      cnt_ext;
  logic [7:0]       char_c;

  assign trigger   = found & ~found_q & (state == ST_IDLE);
  assign last_char = (char_idx == IDX_W'(FRAME_LEN - 1));
  assign tx_start  = trigger | ((state == ST_SEND) & tx_ready & ~last_char);
  assign cnt_ext   = {8'h00, cnt_sh};

  // Character about to be handed over: 'K' at trigger, otherwise the one after char_idx.
  always_comb begin
    char_sel = (state == ST_IDLE) ? '0 : char_idx + IDX_W'(1);
    kpos     = 4'(char_sel - IDX_W'(2));
    cpos     = 4'(char_sel - IDX_W'(21));
    key_nib  = key_sh[{~kpos, 2'b00} +: 4];
    cnt_nib  = cnt_ext[{4'(4'd13 - cpos), 2'b00} +: 4];
    case (char_sel)
      6'd0:    char_c = ASCII_K;
      6'd1:    char_c = ASCII_EQ;
      6'd18:   char_c = ASCII_SP;
      6'd19:   char_c = ASCII_C;
      6'd20:   char_c = ASCII_EQ;
      6'd35:   char_c = ASCII_CR;
      6'd36:   char_c = ASCII_LF;
      default: char_c = (char_sel < 6'd18) ? hex2ascii(key_nib) : hex2ascii(cnt_nib);
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (char_c),
    .tx   (tx),
    .ready(tx_ready)
  );

  // Frame sequencer; found_q resets high so a level already present at reset is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      found_q  <= 1'b1;
      char_idx <= '0;
      key_sh   <= '0;
      cnt_sh   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      found_q <= found;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            key_sh   <= key;
            cnt_sh   <= count;
            char_idx <= '0;
            busy     <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (last_char) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              char_idx <= char_idx + IDX_W'(1);
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_report_tx.sv
// Directed + randomized bench for key_report_tx: logs tx per cycle and decodes frames offline.
module tb_key_report_tx;

  localparam int CPB       = 4;
  localparam int CHAR_CYC  = 10 * CPB;
  localparam int FRAME_CYC = 37 * CHAR_CYC;
  localparam int MAXC      = 30000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        found = 1'b1;
  logic [63:0] key = '0;
  logic [55:0] count = '0;
  logic        tx, busy, done;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic tx_log   [MAXC];
  logic busy_log [MAXC];
  logic done_log [MAXC];

  key_report_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rst  (rst),
    .found(found),
    .key  (key),
    .count(count),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      tx_log[cyc]   = tx;
      busy_log[cyc] = busy;
      done_log[cyc] = done;
    end
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] str_at(input string s, input int i);
    if (i < s.len()) return s[i];
    return 8'h00;
  endfunction

  task automatic check_str(input string tag, input string got, input string exp);
    int at;
    at = -1;
    for (int i = 0; i < 64; i++) begin
      if (at < 0 && (str_at(got, i) != str_at(exp, i) || (i < got.len()) != (i < exp.len())))
        at = i;
    end
    n_chk++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s: observed len %0d char[%0d]=0x%02h expected len %0d char=0x%02h",
             tag, got.len(), at, str_at(got, at), exp.len(), str_at(exp, at));
    end
  endtask

  // Reference model: the ASCII line the host terminal should receive.
  function automatic string hex_ch(input logic [3:0] n);
    int v;
    v = (n < 10) ? 48 + int'(n) : 55 + int'(n);
    return $sformatf("%c", 8'(v));
  endfunction

  function automatic string frame_of(input logic [63:0] k, input logic [55:0] c);
    string s;
    s = "K=";
    for (int i = 15; i >= 0; i--) s = {s, hex_ch(k[i*4 +: 4])};
    s = {s, " C="};
    for (int i = 13; i >= 0; i--) s = {s, hex_ch(c[i*4 +: 4])};
    s = {s, $sformatf("%c%c", 8'd13, 8'd10)};
    return s;
  endfunction

  function automatic int lows(input int a, input int b);
    int n;
    n = 0;
    for (int i = a; i < b; i++) if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) n++;
    return n;
  endfunction

  function automatic int count_bytes(input int a, input int b);
    int n, c;
    n = 0;
    c = a;
    while (c < b) begin
      if (tx_log[c] === 1'b0) begin
        n++;
        c += CHAR_CYC;
      end else begin
        c++;
      end
    end
    return n;
  endfunction

  task automatic decode(input int s, output string got, output int bad);
    got = "";
    bad = 0;
    for (int ch = 0; ch < 37; ch++) begin
      logic [7:0] b8;
      b8 = '0;
      for (int bt = 0; bt < 10; bt++) begin
        int   base;
        logic v;
        base = s + ch * CHAR_CYC + bt * CPB;
        v = tx_log[base];
        for (int k = 1; k < CPB; k++) if (tx_log[base + k] !== v) bad++;
        if (bt == 0 && v !== 1'b0) bad++;
        if (bt == 9 && v !== 1'b1) bad++;
        if (bt >= 1 && bt <= 8) b8[bt - 1] = v;
      end
      got = {got, $sformatf("%c", b8)};
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire(output int t);
    found = 1'b1;
    t = cyc;
  endtask

  task automatic wait_done(input int limit, output int d);
    d = -1;
    for (int i = 0; i < limit && d < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) d = cyc;
    end
    check("done_seen", 64'(d >= 0), 64'd1);
  endtask

  task automatic check_frame(input string tag, input int t, input int d,
                             input logic [63:0] k, input logic [55:0] c);
    string got;
    int    bad, s;
    s = t + 1;
    if (d < 0) return;
    check({tag, "_busy_at_trigger"}, 64'(busy_log[t]), 64'd0);
    check({tag, "_start_bit_latency"}, 64'(tx_log[s]), 64'd0);
    check({tag, "_busy_first_cycle"}, 64'(busy_log[s]), 64'd1);
    check({tag, "_done_cycle"}, 64'(d - s), 64'(FRAME_CYC));
    check({tag, "_busy_last_stop"}, 64'(busy_log[d - 1]), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy_log[d]), 64'd0);
    check({tag, "_done_one_cycle"}, 64'(done_log[d + 1]), 64'd0);
    check({tag, "_byte_count"}, 64'(count_bytes(s, d)), 64'd37);
    decode(s, got, bad);
    check({tag, "_bit_timing"}, 64'(bad), 64'd0);
    check_str({tag, "_text"}, got, frame_of(k, c));
  endtask

  initial begin
    int          t, d, rel, tgt;
    logic [63:0] k;
    logic [55:0] c;
    int          seq[10];
    logic [39:0] got_k, exp_k;

    // Reset with found already high
    key = 64'hDEADBEEFCAFEF00D;
    count = 56'h123456789ABCDE;
    tick(3);
    check("reset_tx", 64'(tx), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    rel = cyc;
    tick(60);
    check("no_frame_after_reset", 64'(lows(rel, rel + 50)), 64'd0);

    // Directed full frame, found then held high past done
    found = 1'b0;
    tick(3);
    k = 64'h0123456789ABCDEF;
    c = 56'h00000000000010;
    key = k;
    count = c;
    fire(t);
    wait_done(FRAME_CYC + 100, d);
    tick(3);
    check_frame("frame1", t, d, k, c);
    seq = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 40; i++) begin
      got_k[i] = tx_log[t + 1 + i];
      exp_k[i] = seq[i / CPB][0];
    end
    check("bit_timing_K", 64'(got_k), 64'(exp_k));
    tick(1600);
    check("held_high_no_retrigger", 64'(lows(d + 1, cyc - 2)), 64'd0);

    // Randomized frames with mid-frame input corruption and ignored edges
    for (int it = 0; it < 3; it++) begin
      found = 1'b0;
      tick(3 + $urandom_range(0, 5));
      k = {$urandom, $urandom};
      c = 56'({$urandom, $urandom});
      key = k;
      count = c;
      fire(t);
      tick($urandom_range(10, 600));
      key = 64'hFFFFFFFFFFFFFFFF;
      count = ~c;
      found = 1'b0;
      tick(2);
      found = 1'b1;
      wait_done(FRAME_CYC + 100, d);
      tick(3);
      check_frame($sformatf("rand%0d", it), t, d, k, c);
      tick(300);
      check($sformatf("rand%0d_no_retrigger", it), 64'(lows(d + 1, cyc - 2)), 64'd0);
    end

    // Reset during data bit 2 of character 5 ('3', bit value 0)
    found = 1'b0;
    tick(3);
    key = 64'h0123456789ABCDEF;
    count = 56'(($urandom));
    fire(t);
    tgt = t + 1 + 5 * CHAR_CYC + 3 * CPB + 1;
    tick(tgt - cyc);
    check("pre_reset_tx", 64'(tx), 64'd0);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("async_reset_tx", 64'(tx), 64'd1);
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_done", 64'(done), 64'd0);
    tick(2);
    rst = 1'b0;
    rel = cyc;
    tick(20);
    check("no_resume_after_reset", 64'(lows(rel, rel + 15)), 64'd0);
    found = 1'b0;
    tick(3);
    k = {$urandom, $urandom};
    c = 56'({$urandom, $urandom});
    key = k;
    count = c;
    fire(t);
    wait_done(FRAME_CYC + 100, d);
    tick(3);
    check_frame("post_reset", t, d, k, c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
